// File: rtl/conv_pkg.sv
// Shared constants for the 5x5 convolution datapath.
// FILTER_SIZE/FILTER_BW/DATA_BW describe the upstream window and operands;
// SUM_W is the width of the convolution sum and WARMUP_LEN the number of
// window-fill outputs to discard. norm_state_e is the normalizer FSM encoding.
package conv_pkg;

    localparam int unsigned FILTER_SIZE = 5;
    localparam int unsigned FILTER_BW   = 8;
    localparam int unsigned DATA_BW     = 12;
    localparam int unsigned SUM_W       = DATA_BW + FILTER_BW;
    localparam int unsigned WARMUP_LEN  = FILTER_SIZE * FILTER_SIZE;

    typedef enum logic {
        StWarmup = 1'b0,
        StRun    = 1'b1
    } norm_state_e;

endpackage

// File: rtl/conv_out_normalizer_if.sv
// Stream bundle for conv_out_normalizer.
// Input side : en (sample strobe), sof, shift, in_data.
// Output side: out_data, out_valid, out_ready (valid/ready handshake).
// master: the environment (producer + consumer); slave: the normalizer.
interface conv_out_normalizer_if
    import conv_pkg::*;
#(
    parameter int unsigned IN_W    = SUM_W,
    parameter int unsigned OUT_W   = DATA_BW,
    parameter int unsigned SHIFT_W = 4
) ();

    logic                 en;
    logic                 sof;
    logic [SHIFT_W-1:0]   shift;
    logic [IN_W-1:0]      in_data;
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output en, sof, shift, in_data, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  en, sof, shift, in_data, out_ready,
        output out_data, out_valid
    );

endinterface

// File: rtl/conv_out_fifo2.sv
// Two-entry in-order synchronous FIFO.
// Ports: clk, rst (sync, active-high), flush (empties, same effect as rst),
// push/push_data, pop, full, empty, head (oldest entry).
// Push while full is accepted only when a pop happens in the same cycle;
// pop while empty is ignored.
module conv_out_fifo2 #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem0_q, mem1_q;
    logic [1:0]   cnt_q;
    logic         do_push, do_pop;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign head    = mem0_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt_q  <= 2'd0;
            mem0_q <= '0;
            mem1_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) mem0_q <= push_data;
                    else               mem1_q <= push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    mem0_q <= mem1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new data lands behind the surviving entry.
                    if (cnt_q == 2'd1) begin
                        mem0_q <= push_data;
                    end else begin
                        mem0_q <= mem1_q;
                        mem1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_out_normalizer.sv
// Output normalizer for the 5x5 convolution buffer.
// Discards the first WARMUP accepted samples after rst/sof, then rounds
// (half-up) and arithmetically right-shifts each sum, saturates to OUT_W
// and queues it in a 2-entry FIFO presented over valid/ready.
// Ports: clk, rst (sync, active-high); bus (slave modport: en, sof, shift,
// in_data, out_data, out_valid, out_ready); sat_flag (sticky clamp),
// drop_cnt (saturating count of samples lost to a full FIFO), warm.
// Build option: define CONV_OUT_RELU_EN to zero negative results after
// saturation (the ReLU clamp does not set sat_flag).
module conv_out_normalizer
    import conv_pkg::*;
#(
    parameter int unsigned IN_W    = SUM_W,
    parameter int unsigned OUT_W   = DATA_BW,
    parameter int unsigned SHIFT_W = 4,
    parameter int unsigned WARMUP  = WARMUP_LEN,
    parameter int unsigned DROP_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_out_normalizer_if.slave  bus,
    output logic                  sat_flag,
    output logic [DROP_W-1:0]     drop_cnt,
    output logic                  warm
);

    localparam int unsigned CntW = $clog2(WARMUP + 1);
    localparam logic signed [IN_W:0] SatMax =
        {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] SatMin =
        {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    norm_state_e         state_q;
    logic [CntW-1:0]     cnt_q;
    logic                s1_valid_q;
    logic signed [IN_W:0] s1_sum_q;
    logic [SHIFT_W-1:0]  s1_shift_q;

    logic [IN_W:0]        rnd;
    logic signed [IN_W:0] sum_d;
    logic signed [IN_W:0] shifted;
    logic [OUT_W-1:0]     result;
    logic                 clamp;
    logic                 push, full, empty, drop;

    // One extra bit so that adding the rounding half cannot overflow.
    always_comb begin
        rnd = '0;
        if (bus.shift != '0) begin
            rnd = {{IN_W{1'b0}}, 1'b1} << (bus.shift - SHIFT_W'(1));
        end
        sum_d = $signed({bus.in_data[IN_W-1], bus.in_data}) + $signed(rnd);
    end

    // Warm-up / run FSM and stage-1 register.
    always_ff @(posedge clk) begin
        if (rst || bus.sof) begin
            state_q    <= StWarmup;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            warm       <= 1'b1;
            if (rst) begin
                s1_sum_q   <= '0;
                s1_shift_q <= '0;
            end
        end else begin
            s1_valid_q <= 1'b0;
            if (bus.en) begin
                case (state_q)
                    StWarmup: begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == CntW'(WARMUP - 1)) begin
                            state_q <= StRun;
                            warm    <= 1'b0;
                        end
                    end
                    default: begin
                        s1_valid_q <= 1'b1;
                        s1_sum_q   <= sum_d;
                        s1_shift_q <= bus.shift;
                    end
                endcase
            end
        end
    end

    // Stage 2: shift, saturate, optional ReLU.
    always_comb begin
        shifted = s1_sum_q >>> s1_shift_q;
        clamp   = 1'b0;
        if (shifted > SatMax) begin
            result = {1'b0, {(OUT_W - 1){1'b1}}};
            clamp  = 1'b1;
        end else if (shifted < SatMin) begin
            result = {1'b1, {(OUT_W - 1){1'b0}}};
            clamp  = 1'b1;
        end else begin
            result = shifted[OUT_W-1:0];
        end
`ifdef CONV_OUT_RELU_EN
        if (result[OUT_W-1]) result = '0;
`endif
    end

    // A sample still in stage 1 when sof arrives is flushed with the FIFO.
    assign push = s1_valid_q & ~bus.sof;
    assign drop = push & full & ~bus.out_ready;

    conv_out_fifo2 #(
        .W (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.sof),
        .push      (push),
        .push_data (result),
        .pop       (bus.out_ready),
        .full      (full),
        .empty     (empty),
        .head      (bus.out_data)
    );

    assign bus.out_valid = ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push && clamp) sat_flag <= 1'b1;
            if (drop && (drop_cnt != {DROP_W{1'b1}})) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_conv_out_normalizer.sv
module tb_conv_out_normalizer;

    localparam int unsigned IN_W    = 20;
    localparam int unsigned OUT_W   = 12;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned DROP_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_out_normalizer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) bus ();

    logic              sat_flag;
    logic [DROP_W-1:0] drop_cnt;
    logic              warm;

    conv_out_normalizer #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W),
        .WARMUP  (25),
        .DROP_W  (DROP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .sat_flag (sat_flag),
        .drop_cnt (drop_cnt),
        .warm     (warm)
    );

    int exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;
    int mon_exp;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef CONV_OUT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Drives one sample for one edge; en stays high so calls chain back-to-back.
    task automatic send(input int d, input int sh, input bit keep, input int exp);
        logic [31:0] dv;
        logic [31:0] sv;
        dv = d;
        sv = sh;
        bus.en      = 1'b1;
        bus.in_data = dv[IN_W-1:0];
        bus.shift   = sv[SHIFT_W-1:0];
        if (keep) exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic warmup();
        for (int i = 0; i < 25; i++) send(7, 0, 1'b0, 0);
        idle(1);
    endtask

    // Scoreboard monitor: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_out: got %0d, expected no output",
                         int'($signed(bus.out_data)));
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", int'($signed(bus.out_data)), mon_exp);
            end
        end
    end

    initial begin
        bus.en        = 1'b0;
        bus.sof       = 1'b0;
        bus.shift     = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_warm", int'(warm), 1);
        rst = 1'b0;

        // 1: warm-up and latency
        for (int i = 0; i < 24; i++) send(7, 0, 1'b0, 0);
        idle(1);
        check("warm_after_24", int'(warm), 1);
        send(7, 0, 1'b0, 0);
        idle(1);
        check("warm_after_25", int'(warm), 0);
        check("no_valid_warmup", int'(bus.out_valid), 0);
        send(100, 0, 1'b1, 100);
        check("lat_valid_e0", int'(bus.out_valid), 0);
        idle(1);
        check("lat_valid_e1", int'(bus.out_valid), 1);
        idle(2);

        // 2: rounding
        send(13, 2, 1'b1, 3);
        send(10, 2, 1'b1, 3);
        send(-13, 2, 1'b1, relu(-3));
        send(-10, 2, 1'b1, relu(-2));
        send(-1, 0, 1'b1, relu(-1));
        send(24, 4, 1'b1, 2);
        idle(4);
        check("sat_after_round", int'(sat_flag), 0);

        // 3: saturation
        send(5000, 0, 1'b1, 2047);
        idle(3);
        check("sat_set", int'(sat_flag), 1);
        send(-5000, 0, 1'b1, relu(-2048));
        idle(4);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst2_sat_flag", int'(sat_flag), 0);
        check("rst2_warm", int'(warm), 1);
        check("rst2_out_valid", int'(bus.out_valid), 0);
        rst = 1'b0;
        warmup();

        // 4: backpressure and drop
        bus.out_ready = 1'b0;
        send(10, 0, 1'b1, 10);
        send(20, 0, 1'b1, 20);
        send(30, 0, 1'b0, 0);
        idle(3);
        check("bp_drop_cnt", int'(drop_cnt), 1);
        check("bp_valid", int'(bus.out_valid), 1);
        check("bp_head", int'($signed(bus.out_data)), 10);
        idle(2);
        check("bp_head_stable", int'($signed(bus.out_data)), 10);
        bus.out_ready = 1'b1;
        idle(4);
        check("bp_drained", int'(bus.out_valid), 0);

        // 5: sof with a full FIFO and a simultaneous en
        bus.out_ready = 1'b0;
        send(50, 0, 1'b1, 50);
        send(60, 0, 1'b1, 60);
        idle(3);
        check("pre_sof_valid", int'(bus.out_valid), 1);
        check("pre_sof_head", int'($signed(bus.out_data)), 50);
        exp_q.delete();
        bus.sof     = 1'b1;
        bus.en      = 1'b1;
        bus.in_data = 20'd999;
        bus.shift   = '0;
        @(posedge clk);
        #1;
        bus.sof = 1'b0;
        bus.en  = 1'b0;
        check("sof_valid", int'(bus.out_valid), 0);
        check("sof_warm", int'(warm), 1);
        bus.out_ready = 1'b1;
        warmup();
        send(77, 0, 1'b1, 77);
        idle(4);
        check("sof_drop_kept", int'(drop_cnt), 1);

        // 6: negative pass-through or ReLU
        send(-40, 0, 1'b1, relu(-40));
        send(40, 0, 1'b1, 40);
        idle(4);
        check("relu_sat_flag", int'(sat_flag), 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_out_normalizer.md
Name: conv_out_normalizer

Overview:
- Downstream stage of the 5x5 2D convolution buffer. Takes the signed convolution sum and the shared sample strobe `en`.
- Discards the warm-up outputs produced while the window is still filling. Applies a programmable right shift with round-half-up, then saturates to pixel width.
- Delivers results over a valid/ready interface through a 2-entry output FIFO. Keeps sticky saturation and drop diagnostics.

Parameters:
- IN_W, 20, width of the convolution sum input (12-bit data + 8-bit coeff).
- OUT_W, 12, output pixel width.
- SHIFT_W, 4, width of the shift control (0..15).
- WARMUP, 25, number of accepted samples discarded after reset/sof (FILTER_SIZE*FILTER_SIZE).
- DROP_W, 8, width of the drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  sample strobe, same as upstream enable; in_data is valid in the cycle en=1
- sof  in  1  start-of-frame pulse; restarts warm-up and flushes the pipeline
- shift  in  SHIFT_W  right-shift amount, sampled with each accepted sample
- in_data  in  IN_W  signed convolution sum
- out_data  out  OUT_W  signed normalized pixel (FIFO head)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accept; pop when out_valid & out_ready
- sat_flag  out  1  sticky; set on any clamp
- drop_cnt  out  DROP_W  saturating count of samples lost to a full FIFO
- warm  out  1  high while in WARMUP state

Behaviour:
- Interface decision: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - out_valid=0, out_data=0, sat_flag=0, drop_cnt=0, warm=1.
  - FIFO empty, stage-1 valid=0, warm-up counter=0, state=WARMUP.
- Priority: rst > sof > en.
- FSM (states WARMUP, RUN):
  - WARMUP: each en increments the counter and the sample is discarded. On the en that brings the count to WARMUP, move to RUN; that sample is still discarded.
  - RUN: each en loads stage 1.
  - sof, from any state: state=WARMUP, counter=0, stage-1 valid=0, FIFO emptied. sat_flag and drop_cnt are kept. An en in the same cycle as sof is ignored.
- Stage 1 (edge E0, when en=1 in RUN):
  - Register in_data and shift.
  - Form sum = in_data + (shift==0 ? 0 : 1<<(shift-1)) in IN_W+1 bits, so the addition cannot overflow.
- Stage 2 (edge E1, combinational from stage-1 registers, written into the FIFO):
  - Arithmetic right shift of sum by shift.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If a clamp occurs, set sat_flag at the same edge.
- Latency: en at E0 gives out_valid=1 in the cycle after E1, i.e. 2 cycles when the FIFO is empty.
- Throughput: one sample per cycle with en held high.
- FIFO (depth 2, in-order):
  - Push and pop in the same cycle are both allowed, including when full.
  - Push while full with no pop: the sample is dropped and drop_cnt increments, saturating at all-ones.
  - Pop while empty is ignored.
- out_data holds the head value. It is stable while out_valid=1 and out_ready=0.
- sat_flag and drop_cnt clear only on rst.

Optional Feature:
- Macro: CONV_OUT_RELU_EN.
- Defined: after saturation, negative results are replaced by 0. sat_flag is not set by the ReLU clamp.
- Undefined: signed output passes unchanged.

Decomposition:
- Package conv_pkg holds:
  - FILTER_SIZE=5, FILTER_BW=8, DATA_BW=12.
  - Derived SUM_W=DATA_BW+FILTER_BW.
  - WARMUP default = FILTER_SIZE*FILTER_SIZE.
  - State encoding constants WARMUP/RUN.
- One sub-module: conv_out_fifo2, a 2-entry synchronous FIFO with push/pop/full/empty.

Test Plan:
1. Warm-up and latency: rst, then 25 en samples of value 7 produce no out_valid. The 26th sample, in=100 with shift=0, gives out_data=100 with out_valid two cycles later, and warm=0.
2. Rounding with shift=2:
   - in=13 -> 3.
   - in=10 -> 3 (half rounds up).
   - in=-13 -> -3.
   - in=-10 -> -2.
   - shift=0, in=-1 -> -1.
3. Saturation with OUT_W=12, shift=0:
   - in=5000 -> 2047 and sat_flag=1.
   - in=-5000 -> -2048.
   - After rst, sat_flag=0.
4. Backpressure with out_ready=0: after warm-up send 10, 20, 30 on consecutive cycles. 10 and 20 are held and 30 is dropped, giving drop_cnt=1. Then raise out_ready: 10 then 20 pop, and out_valid falls.
5. sof mid-stream with the FIFO holding 2 entries:
   - sof plus a simultaneous en: out_valid=0 next cycle, warm=1, and the en sample is ignored.
   - The next 25 samples are discarded; the 26th is output.
   - drop_cnt is unchanged.
6. CONV_OUT_RELU_EN defined: in=-40 with shift=0 -> 0, and sat_flag stays 0. in=40 -> 40.
